// File: rtl/lsu_pkg.sv
// Shared LSU types: access size, FSM states, size encodings and helpers.
// Imported by lsu_align and lsu_nzlat.
package lsu_pkg;

   typedef enum logic [1:0] {
      LSU_B = 2'd0,
      LSU_H = 2'd1,
      LSU_W = 2'd2
   } lsu_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Encoding 3 is folded into word.
   function automatic lsu_size_e lsu_decode_size(input logic [1:0] sz);
      lsu_size_e s;
      unique case (1'b1)
         (sz == SZ_BYTE): s = LSU_B;
         (sz == SZ_HALF): s = LSU_H;
         default:         s = LSU_W;
      endcase
      return s;
   endfunction

   function automatic logic lsu_misaligned(input lsu_size_e sz,
                                           input logic [1:0] off);
      logic m;
      unique case (sz)
         LSU_H:   m = off[0];
         LSU_W:   m = |off;
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   function automatic logic [1:0] lsu_force_align(input lsu_size_e sz,
                                                  input logic [1:0] off);
      logic [1:0] o;
      unique case (sz)
         LSU_H:   o = {off[1], 1'b0};
         LSU_W:   o = 2'b00;
         default: o = off;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store byte enables / replicated data, load extract + extend.
// Ports: size, off, we, unsigned_ld, wdata_in, rdata_in -> wstrb, wdata_out, rdata_out.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            off,
   input  lsu_size_e             size,
   input  logic                  we,
   input  logic                  unsigned_ld,
   input  logic [DATA_WIDTH-1:0] wdata_in,
   input  logic [DATA_WIDTH-1:0] rdata_in,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic [DATA_WIDTH-1:0] wdata_out,
   output logic [DATA_WIDTH-1:0] rdata_out
);

   logic [DATA_WIDTH-1:0] shifted;
   logic                  sx;

   always_comb begin
      shifted   = rdata_in >> {off, 3'b000};
      sx        = 1'b0;
      wstrb     = 4'b1111;
      wdata_out = wdata_in;
      rdata_out = shifted;
      unique case (size)
         LSU_B: begin
            wstrb     = 4'b0001 << off;
            wdata_out = {4{wdata_in[7:0]}};
            sx        = ~unsigned_ld & shifted[7];
            rdata_out = {{24{sx}}, shifted[7:0]};
         end
         LSU_H: begin
            wstrb     = 4'b0011 << off;
            wdata_out = {2{wdata_in[15:0]}};
            sx        = ~unsigned_ld & shifted[15];
            rdata_out = {{16{sx}}, shifted[15:0]};
         end
         default: begin
            wstrb     = 4'b1111;
            wdata_out = wdata_in;
            rdata_out = shifted;
         end
      endcase
      if (!we) wstrb = '0;
   end

endmodule

// File: rtl/lsu_nzlat.sv
// Load/store unit for a memory port with any latency, including zero.
// Ports: clk, rst_n (async, active-high), req_* in, rsp_* out, mem_* port.
// Build macro LSU_MISALIGN_TRAP_EN: misaligned requests trap instead of aligning.
module lsu_nzlat
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_we_i,
   input  logic [1:0]              req_size_i,
   input  logic                    req_unsigned_i,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   output logic                    rsp_valid_o,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
   output logic                    mem_read_o,
   output logic                    mem_write_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    mem_ready_i
);

   lsu_state_e            state_q, state_d;
   logic                  we_q, uns_q;
   lsu_size_e             size_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q;

   logic                  accept, busy, trap;
   lsu_size_e             req_size;
   logic [ADDR_WIDTH-1:0] addr_in;
   logic [DATA_WIDTH/8-1:0] al_wstrb;
   logic [DATA_WIDTH-1:0] al_wdata, al_rdata;

   assign req_size = lsu_decode_size(req_size_i);

`ifdef LSU_MISALIGN_TRAP_EN
   logic err_q;
   assign trap    = lsu_misaligned(req_size, req_addr_i[1:0]);
   assign addr_in = req_addr_i;
   assign rsp_err_o = err_q;
`else
   assign trap    = 1'b0;
   assign addr_in = {req_addr_i[ADDR_WIDTH-1:2],
                     lsu_force_align(req_size, req_addr_i[1:0])};
   assign rsp_err_o = 1'b0;
`endif

   // Ready drops while reset is held so nothing is accepted mid-reset.
   assign req_ready_o = (state_q == IDLE) && !rst_n;
   assign accept      = req_valid_i && req_ready_o;
   assign busy        = (state_q == BUSY);
   assign rsp_valid_o = (state_q == DONE);
   assign rsp_rdata_o = rdata_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = trap ? DONE : BUSY;
         BUSY:    if (mem_ready_i) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= LSU_B;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         err_q   <= 1'b0;
`endif
      end else begin
         if (accept) begin
            we_q    <= req_we_i;
            uns_q   <= req_unsigned_i;
            size_q  <= req_size;
            addr_q  <= addr_in;
            wdata_q <= req_wdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
            if (trap) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end
`endif
         end
         if (busy && mem_ready_i) begin
            rdata_q <= we_q ? '0 : al_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
         end
      end
   end

   lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .off         (addr_q[1:0]),
      .size        (size_q),
      .we          (we_q),
      .unsigned_ld (uns_q),
      .wdata_in    (wdata_q),
      .rdata_in    (mem_rdata_i),
      .wstrb       (al_wstrb),
      .wdata_out   (al_wdata),
      .rdata_out   (al_rdata)
   );

   // Port outputs are only live while an access is outstanding.
   assign mem_read_o  = busy && !we_q;
   assign mem_write_o = busy && we_q;
   assign mem_addr_o  = busy ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign mem_wdata_o = mem_write_o ? al_wdata : '0;
   assign mem_wstrb_o = mem_write_o ? al_wstrb : '0;

endmodule

// File: tb/tb_lsu_nzlat.sv
// Directed bench for lsu_nzlat against a latency-programmable memory model.
// Ports: all DUT ports driven/observed here.
module tb_lsu_nzlat;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
   logic [1:0]  req_size_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_wstrb_o;
   logic        mem_read_o, mem_write_o, mem_ready_i;

   always #5 clk = ~clk;

   lsu_nzlat #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_size_i(req_size_i),
      .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_wstrb_o(mem_wstrb_o), .mem_read_o(mem_read_o),
      .mem_write_o(mem_write_o), .mem_rdata_i(mem_rdata_i),
      .mem_ready_i(mem_ready_i)
   );

   logic [31:0] mem [0:63];
   int          lat = 5;
   int          cnt = 0;
   logic        extra_ready = 1'b0;
   logic        strobe;

   assign strobe      = mem_read_o | mem_write_o;
   assign mem_ready_i = (strobe && cnt == lat) || extra_ready;
   assign mem_rdata_i = mem[mem_addr_o[7:2]];

   always @(posedge clk) begin
      if (strobe && !mem_ready_i) cnt <= cnt + 1;
      else                        cnt <= 0;
      if (mem_write_o && mem_ready_i)
         for (int b = 0; b < 4; b++)
            if (mem_wstrb_o[b])
               mem[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
   end

   int nvec = 0;
   int nbad = 0;

   logic [31:0] r_rdata, r_addr, r_wdata;
   logic [3:0]  r_strb;
   logic        r_err, r_rd, r_wr, r_stable, r_after, r_pulse1;
   int          r_cyc;

   task automatic run_req(input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr,
                          input logic [31:0] wdata);
      logic first, prev_rdy;
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = we; req_size_i = sz;
      req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
      @(negedge clk);
      req_valid_i = 1'b0;
      r_cyc = 1; r_rd = 0; r_wr = 0; r_stable = 1; first = 1;
      prev_rdy = 0; r_addr = 0; r_strb = 0; r_wdata = 0;
      while (!rsp_valid_o && r_cyc < 50) begin
         if (strobe) begin
            if (first) begin
               r_addr = mem_addr_o; r_strb = mem_wstrb_o;
               r_wdata = mem_wdata_o; first = 0;
            end else if (mem_addr_o !== r_addr ||
                         mem_wstrb_o !== r_strb ||
                         mem_wdata_o !== r_wdata) r_stable = 0;
            r_rd |= mem_read_o; r_wr |= mem_write_o;
         end
         prev_rdy = mem_ready_i;
         @(negedge clk);
         r_cyc++;
      end
      r_after = prev_rdy;
      r_rdata = rsp_rdata_o; r_err = rsp_err_o;
      @(negedge clk);
      r_pulse1 = !rsp_valid_o && (rsp_rdata_o === r_rdata);
   endtask

   task automatic test_reset();
      rst_n = 1'b1; req_valid_i = 0; req_we_i = 0; req_size_i = 0;
      req_unsigned_i = 0; req_addr_i = 0; req_wdata_i = 0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      @(negedge clk);
      nvec++;
      if ({mem_read_o, mem_write_o, rsp_valid_o, rsp_err_o} !== 4'b0) begin
         nbad++; $display("FAIL reset_strobes got %b want 0000",
            {mem_read_o, mem_write_o, rsp_valid_o, rsp_err_o});
      end
      nvec++;
      if ({rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== 100'h0) begin
         nbad++; $display("FAIL reset_data got %h %h %h %h want 0",
            rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_wstrb_o);
      end
      rst_n = 1'b0;
      #1;
      nvec++;
      if (req_ready_o !== 1'b1) begin
         nbad++; $display("FAIL reset_ready got %b want 1", req_ready_o);
      end
   endtask

   task automatic test_store_word();
      run_req(1, 2'd2, 0, 32'h40, 32'hDEADBEEF);
      nvec++;
      if ({r_wr, r_rd, r_stable, r_after, r_pulse1, r_err} !== 6'b101110) begin
         nbad++; $display("FAIL sw_flags got %b want 101110",
            {r_wr, r_rd, r_stable, r_after, r_pulse1, r_err});
      end
      nvec++;
      if (r_addr !== 32'h40 || r_strb !== 4'hF || r_wdata !== 32'hDEADBEEF) begin
         nbad++; $display("FAIL sw_port got %h %h %h want 40 f deadbeef",
            r_addr, r_strb, r_wdata);
      end
      nvec++;
      if (r_cyc !== 7 || r_rdata !== 32'h0) begin
         nbad++; $display("FAIL sw_rsp got cyc %0d rdata %h want 7 0",
            r_cyc, r_rdata);
      end
      nvec++;
      if (mem[16] !== 32'hDEADBEEF) begin
         nbad++; $display("FAIL sw_mem got %h want deadbeef", mem[16]);
      end
   endtask

   task automatic test_store_subword();
      run_req(1, 2'd0, 0, 32'h43, 32'h000000A5);
      nvec++;
      if (r_addr !== 32'h40 || r_strb !== 4'h8 || r_wdata !== 32'hA5A5A5A5) begin
         nbad++; $display("FAIL sb_port got %h %h %h want 40 8 a5a5a5a5",
            r_addr, r_strb, r_wdata);
      end
      nvec++;
      if (mem[16] !== 32'hA5ADBEEF) begin
         nbad++; $display("FAIL sb_mem got %h want a5adbeef", mem[16]);
      end
      run_req(1, 2'd2, 0, 32'h40, 32'h123480FF);
      nvec++;
      if (mem[16] !== 32'h123480FF) begin
         nbad++; $display("FAIL sw2_mem got %h want 123480ff", mem[16]);
      end
   endtask

   task automatic test_loads();
      logic [1:0]  sz  [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
      logic        un  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] ad  [6] = '{32'h41, 32'h41, 32'h42, 32'h40, 32'h40, 32'h40};
      logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00001234,
                               32'hFFFF80FF, 32'h000080FF, 32'h123480FF};
      for (int i = 0; i < 6; i++) begin
         run_req(0, sz[i], un[i], ad[i], 32'hFFFFFFFF);
         nvec++;
         if (r_rdata !== exp[i] || r_err !== 1'b0 || r_rd !== 1'b1 ||
             r_strb !== 4'h0 || r_addr !== 32'h40 || r_cyc !== 7) begin
            nbad++;
            $display("FAIL load%0d got %h err %b rd %b strb %h cyc %0d want %h",
               i, r_rdata, r_err, r_rd, r_strb, r_cyc, exp[i]);
         end
      end
   endtask

   task automatic test_store_half();
      run_req(1, 2'd1, 0, 32'h42, 32'h0000CAFE);
      nvec++;
      if (r_strb !== 4'hC || r_wdata !== 32'hCAFECAFE ||
          mem[16] !== 32'hCAFE80FF) begin
         nbad++; $display("FAIL sh got strb %h wdata %h mem %h want c cafecafe cafe80ff",
            r_strb, r_wdata, mem[16]);
      end
   endtask

   task automatic test_misalign();
      run_req(0, 2'd2, 0, 32'h41, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      nvec++;
      if (r_rd !== 1'b0 || r_cyc !== 1 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
         nbad++; $display("FAIL lw_mis got rd %b cyc %0d err %b rdata %h want 0 1 1 0",
            r_rd, r_cyc, r_err, r_rdata);
      end
      run_req(0, 2'd1, 0, 32'h43, 32'h0);
      nvec++;
      if (r_rd !== 1'b0 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
         nbad++; $display("FAIL lh_mis got rd %b err %b rdata %h want 0 1 0",
            r_rd, r_err, r_rdata);
      end
`else
      nvec++;
      if (r_rd !== 1'b1 || r_addr !== 32'h40 || r_err !== 1'b0 ||
          r_rdata !== 32'hCAFE80FF || r_cyc !== 7) begin
         nbad++; $display("FAIL lw_mis got rd %b addr %h err %b rdata %h cyc %0d",
            r_rd, r_addr, r_err, r_rdata, r_cyc);
      end
      run_req(0, 2'd1, 0, 32'h43, 32'h0);
      nvec++;
      if (r_err !== 1'b0 || r_rdata !== 32'hFFFFCAFE) begin
         nbad++; $display("FAIL lh_mis got err %b rdata %h want 0 ffffcafe",
            r_err, r_rdata);
      end
`endif
   endtask

   task automatic test_zero_lat();
      lat = 0;
      run_req(0, 2'd2, 0, 32'h40, 32'h0);
      nvec++;
      if (r_cyc !== 2 || r_rdata !== 32'hCAFE80FF || r_after !== 1'b1) begin
         nbad++; $display("FAIL zl_lw got cyc %0d rdata %h want 2 cafe80ff",
            r_cyc, r_rdata);
      end
      run_req(1, 2'd0, 0, 32'h40, 32'h00000011);
      nvec++;
      if (r_cyc !== 2 || mem[16] !== 32'hCAFE8011) begin
         nbad++; $display("FAIL zl_sb got cyc %0d mem %h want 2 cafe8011",
            r_cyc, mem[16]);
      end
      lat = 5;
   endtask

   task automatic test_reset_busy();
      logic saw_rsp;
      @(negedge clk);
      req_valid_i = 1; req_we_i = 0; req_size_i = 2'd2; req_addr_i = 32'h40;
      @(negedge clk);
      req_valid_i = 0;
      @(negedge clk);
      @(negedge clk);
      nvec++;
      if (mem_read_o !== 1'b1) begin
         nbad++; $display("FAIL rb_pre got read %b want 1", mem_read_o);
      end
      rst_n = 1'b1;
      #1;
      nvec++;
      if (mem_read_o !== 1'b0 || rsp_valid_o !== 1'b0 || mem_addr_o !== 32'h0) begin
         nbad++; $display("FAIL rb_async got read %b rsp %b addr %h want 0 0 0",
            mem_read_o, rsp_valid_o, mem_addr_o);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      nvec++;
      if (req_ready_o !== 1'b1) begin
         nbad++; $display("FAIL rb_ready got %b want 1", req_ready_o);
      end
      saw_rsp = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         extra_ready = (i == 2);
         saw_rsp |= rsp_valid_o | strobe;
      end
      extra_ready = 0;
      nvec++;
      if (saw_rsp !== 1'b0 || req_ready_o !== 1'b1) begin
         nbad++; $display("FAIL rb_late got rsp %b ready %b want 0 1",
            saw_rsp, req_ready_o);
      end
      run_req(0, 2'd2, 0, 32'h40, 32'h0);
      nvec++;
      if (r_rdata !== 32'hCAFE8011 || r_cyc !== 7 || r_err !== 1'b0) begin
         nbad++; $display("FAIL rb_after got rdata %h cyc %0d want cafe8011 7",
            r_rdata, r_cyc);
      end
   endtask

   task automatic test_back_to_back();
      int          n_acc, n_rsp, last_rsp;
      logic        overlap, bad_gap;
      logic [31:0] rd [2];
      n_acc = 0; n_rsp = 0; last_rsp = -10; overlap = 0; bad_gap = 0;
      rd[0] = 0; rd[1] = 0;
      @(negedge clk);
      req_valid_i = 1; req_we_i = 0; req_size_i = 2'd2;
      req_unsigned_i = 0; req_addr_i = 32'h40;
      for (int i = 0; i < 40 && n_rsp < 2; i++) begin
         if (strobe && (req_ready_o || rsp_valid_o)) overlap = 1;
         if (rsp_valid_o) begin
            rd[n_rsp] = rsp_rdata_o; n_rsp++; last_rsp = i;
         end
         if (req_ready_o && req_valid_i) begin
            n_acc++;
            if (n_acc == 2 && i != last_rsp + 1) bad_gap = 1;
         end
         @(negedge clk);
         if (n_acc == 1) begin
            req_size_i = 2'd0; req_addr_i = 32'h41;
         end
         if (n_acc == 2) req_valid_i = 0;
      end
      req_valid_i = 0;
      nvec++;
      if (n_acc !== 2 || n_rsp !== 2 || bad_gap !== 1'b0 || overlap !== 1'b0) begin
         nbad++; $display("FAIL b2b_seq got acc %0d rsp %0d gap %b ovl %b want 2 2 0 0",
            n_acc, n_rsp, bad_gap, overlap);
      end
      nvec++;
      if (rd[0] !== 32'hCAFE8011 || rd[1] !== 32'hFFFFFF80) begin
         nbad++; $display("FAIL b2b_data got %h %h want cafe8011 ffffff80",
            rd[0], rd[1]);
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_store_subword();
      test_loads();
      test_store_half();
      test_misalign();
      test_zero_lat();
      test_reset_busy();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
